// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requests, hazard probes and the reg-file write port.
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            vld0;
    logic            rdy0;
    logic [AW-1:0]   addr0;
    logic [XLEN-1:0] data0;
    logic            vld1;
    logic            rdy1;
    logic [AW-1:0]   addr1;
    logic [XLEN-1:0] data1;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic            hz1;
    logic            hz2;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            idle;

    modport master (
        output vld0, addr0, data0, vld1, addr1, data1, a1, a2,
        input  rdy0, rdy1, hz1, hz2, we3, a3, wd3, idle
    );

    modport slave (
        input  vld0, addr0, data0, vld1, addr1, data1, a1, a2,
        output rdy0, rdy1, hz1, hz2, we3, a3, wd3, idle
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two per-requester FIFOs drained round-robin into a registered reg-file write port,
// with read-after-write hazard flags for pending writes.
module rf_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]   q_addr [2][DEPTH];
    logic [XLEN-1:0] q_data [2][DEPTH];
    logic [PW-1:0]   wp [2];
    logic [PW-1:0]   rp [2];
    logic [CW-1:0]   cnt [2];
    logic [AW-1:0]   in_addr [2];
    logic [XLEN-1:0] in_data [2];
    logic [AW-1:0]   rd_addr [2];
    logic [1:0]      vld, full, empty, push, pop, hz;
    logic            last, sel, both;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;

    // writes to x0 finish the handshake but are dropped here
    always_comb begin
        vld        = {bus.vld1, bus.vld0};
        in_addr[0] = bus.addr0;
        in_addr[1] = bus.addr1;
        in_data[0] = bus.data0;
        in_data[1] = bus.data1;
        for (int p = 0; p < 2; p++) begin
            full[p]  = cnt[p] == CW'(DEPTH);
            empty[p] = cnt[p] == '0;
            push[p]  = vld[p] && !full[p] && in_addr[p] != '0;
        end
        both   = !empty[0] && !empty[1];
        sel    = both ? !last : empty[0];
        pop[0] = !empty[0] && !sel;
        pop[1] = !empty[1] && sel;
    end

    // an entry is live when its offset from the read pointer is below the count
    always_comb begin
        rd_addr[0] = bus.a1;
        rd_addr[1] = bus.a2;
        for (int h = 0; h < 2; h++) begin
            hz[h] = we3 && a3 == rd_addr[h];
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < DEPTH; i++)
                    if (CW'(i) < cnt[p] && q_addr[p][PW'((int'(rp[p]) + i) % DEPTH)] == rd_addr[h])
                        hz[h] = 1'b1;
            hz[h] = hz[h] && rd_addr[h] != '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            if (push[p]) begin
                q_addr[p][wp[p]] <= in_addr[p];
                q_data[p][wp[p]] <= in_data[p];
            end
    end

    // last=1 means port 1 was granted last, so port 0 wins the next tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                wp[p]  <= '0;
                rp[p]  <= '0;
                cnt[p] <= '0;
            end
            last <= 1'b1;
            we3  <= 1'b0;
            a3   <= '0;
            wd3  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) wp[p] <= wp[p] == PW'(DEPTH - 1) ? '0 : wp[p] + 1'b1;
                if (pop[p]) rp[p] <= rp[p] == PW'(DEPTH - 1) ? '0 : rp[p] + 1'b1;
                cnt[p] <= cnt[p] + CW'(push[p]) - CW'(pop[p]);
            end
            if (both) last <= sel;
            we3 <= |pop;
            if (|pop) begin
                a3  <= q_addr[sel][rp[sel]];
                wd3 <= q_data[sel][rp[sel]];
            end
        end
    end

    assign bus.rdy0 = !full[0];
    assign bus.rdy1 = !full[1];
    assign bus.hz1  = hz[0];
    assign bus.hz2  = hz[1];
    assign bus.we3  = we3;
    assign bus.a3   = a3;
    assign bus.wd3  = wd3;
    assign bus.idle = empty[0] && empty[1] && !we3;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for the writeback arbiter; per-port expected writes are
// queued on handshake and matched against each reg-file write.
module tb_rf_wb_arbiter;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    ent_t q0[$];
    ent_t q1[$];
    logic [4:0] seq[$];
    logic rec = 1'b0;

    rf_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    rf_wb_arbiter #(.XLEN(32), .AW(5), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.vld0 = 1'b0;
        bus.vld1 = 1'b0;
    endtask

    task automatic reset_dut;
        idle_inputs();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        tick();
        reset = 1'b0;
    endtask

    // retire the write seen this cycle, then queue whatever handshakes at the next edge
    always @(negedge clk) begin
        ent_t e;
        logic found;
        if (bus.we3) begin
            found = 1'b0;
            if (q0.size() > 0 && q0[0].a == bus.a3) begin
                e = q0.pop_front();
                found = 1'b1;
            end else if (q1.size() > 0 && q1[0].a == bus.a3) begin
                e = q1.pop_front();
                found = 1'b1;
            end
            chk("wr_expected", {63'd0, found}, 64'd1);
            if (found) chk("wd3", {32'd0, bus.wd3}, {32'd0, e.d});
            if (rec) seq.push_back(bus.a3);
        end
        if (!reset && bus.vld0 && bus.rdy0 && bus.addr0 != 5'd0) q0.push_back({bus.addr0, bus.data0});
        if (!reset && bus.vld1 && bus.rdy1 && bus.addr1 != 5'd0) q1.push_back({bus.addr1, bus.data1});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_rdy;
        idle_inputs();
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.data0 = '0;
        bus.data1 = '0;
        bus.a1 = '0;
        bus.a2 = '0;
        #1;
        chk("rst_we3", {63'd0, bus.we3}, 64'd0);
        chk("rst_idle", {63'd0, bus.idle}, 64'd1);
        chk("rst_rdy", {62'd0, bus.rdy0, bus.rdy1}, 64'd3);
        tick();
        tick();
        reset = 1'b0;

        // single write, latency and hazard window
        bus.a1 = 5'd5;
        bus.a2 = 5'd6;
        bus.vld0 = 1'b1;
        bus.addr0 = 5'd5;
        bus.data0 = 32'hDEADBEEF;
        #1;
        chk("hz1_inputs_ignored", {63'd0, bus.hz1}, 64'd0);
        tick();
        bus.vld0 = 1'b0;
        chk("k_hz1", {63'd0, bus.hz1}, 64'd1);
        chk("k_hz2", {63'd0, bus.hz2}, 64'd0);
        chk("k_we3", {63'd0, bus.we3}, 64'd0);
        chk("k_idle", {63'd0, bus.idle}, 64'd0);
        tick();
        chk("k1_we3", {63'd0, bus.we3}, 64'd1);
        chk("k1_a3", {59'd0, bus.a3}, 64'd5);
        chk("k1_wd3", {32'd0, bus.wd3}, 64'hDEADBEEF);
        chk("k1_hz1", {63'd0, bus.hz1}, 64'd1);
        tick();
        chk("k2_we3", {63'd0, bus.we3}, 64'd0);
        chk("k2_hz1", {63'd0, bus.hz1}, 64'd0);
        chk("k2_idle", {63'd0, bus.idle}, 64'd1);
        chk("k2_a3_hold", {59'd0, bus.a3}, 64'd5);

        // both ports saturated: rdy pattern after edge n is 11, then 10 on even, 01 on odd
        reset_dut();
        rec = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            bus.vld0 = 1'b1;
            bus.vld1 = 1'b1;
            bus.addr0 = 5'd1;
            bus.addr1 = 5'd2;
            bus.data0 = 32'h1000 + n;
            bus.data1 = 32'h2000 + n;
            tick();
            exp_rdy = n == 1 ? 2'b11 : (n % 2 == 0 ? 2'b10 : 2'b01);
            chk("sat_rdy", {62'd0, bus.rdy0, bus.rdy1}, {62'd0, exp_rdy});
        end
        idle_inputs();
        repeat (6) tick();
        rec = 1'b0;
        chk("sat_count", seq.size(), 64'd10);
        for (int i = 0; i < seq.size(); i++)
            chk("sat_order", {59'd0, seq[i]}, i % 2 == 0 ? 64'd1 : 64'd2);
        chk("sat_q_empty", q0.size() + q1.size(), 64'd0);

        // port 1 alone: one write per cycle, never back-pressured
        for (int i = 0; i < 4; i++) begin
            bus.vld1 = 1'b1;
            bus.addr1 = 5'(3 + i);
            bus.data1 = 32'hA0 + i;
            #1;
            chk("p1_rdy", {63'd0, bus.rdy1}, 64'd1);
            tick();
            if (i > 0) chk("p1_a3", {59'd0, bus.a3}, 64'(2 + i));
        end
        bus.vld1 = 1'b0;
        tick();
        chk("p1_a3_last", {59'd0, bus.a3}, 64'd6);
        chk("p1_we3_last", {63'd0, bus.we3}, 64'd1);
        tick();
        chk("p1_we3_done", {63'd0, bus.we3}, 64'd0);

        // x0 write is accepted and discarded
        bus.a1 = 5'd0;
        bus.vld0 = 1'b1;
        bus.addr0 = 5'd0;
        bus.data0 = 32'h12345678;
        #1;
        chk("x0_rdy", {63'd0, bus.rdy0}, 64'd1);
        tick();
        bus.vld0 = 1'b0;
        chk("x0_idle", {63'd0, bus.idle}, 64'd1);
        chk("x0_hz1", {63'd0, bus.hz1}, 64'd0);
        tick();
        chk("x0_we3", {63'd0, bus.we3}, 64'd0);
        chk("x0_idle2", {63'd0, bus.idle}, 64'd1);

        // load both FIFOs, then reset asynchronously mid-cycle
        bus.a1 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            bus.vld0 = 1'b1;
            bus.vld1 = 1'b1;
            bus.addr0 = 5'd7;
            bus.addr1 = 5'd8;
            bus.data0 = 32'h700 + i;
            bus.data1 = 32'h800 + i;
            tick();
        end
        chk("pre_rst_idle", {63'd0, bus.idle}, 64'd0);
        #2;
        reset = 1'b1;
        idle_inputs();
        #1;
        q0.delete();
        q1.delete();
        chk("arst_we3", {63'd0, bus.we3}, 64'd0);
        chk("arst_a3", {59'd0, bus.a3}, 64'd0);
        chk("arst_wd3", {32'd0, bus.wd3}, 64'd0);
        chk("arst_rdy", {62'd0, bus.rdy0, bus.rdy1}, 64'd3);
        chk("arst_idle", {63'd0, bus.idle}, 64'd1);
        chk("arst_hz1", {63'd0, bus.hz1}, 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_we3", {63'd0, bus.we3}, 64'd0);
            chk("post_rst_idle", {63'd0, bus.idle}, 64'd1);
        end
        chk("final_q_empty", q0.size() + q1.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
